// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
//
// Pipelined immediate generator for the decode stage. Instruction bits [31:7]
// arrive with an immediate-select code on a valid/ready handshake. The
// immediate is formed combinationally, extended to XLEN bits and written into
// a 2-entry output buffer together with a sideband tag and an illegal-shamt
// flag. Every output is driven from buffer registers; nothing on the input
// side reaches an output combinationally except IN_READY's dependence on RESET.
//
// Parameters
//   XLEN   output width, 32 or 64 (anything else stops elaboration)
//   TAG_W  width of the sideband tag
//
// Ports
//   CLK          clock, all state updates on the rising edge
//   RESET        synchronous active-high reset (priority over FLUSH)
//   FLUSH        synchronous buffer clear (priority over push and pop)
//   IN[24:0]     instruction[31:7]
//   IMM_SEL[2:0] immediate format select
//   IN_TAG       sideband tag travelling with the beat
//   IN_VALID     input beat valid
//   IN_READY     buffer can accept a beat (not full, not in reset)
//   OUT          extended immediate of the head entry
//   OUT_TAG      tag of the head entry
//   OUT_ILLEGAL  head entry carried a shift amount out of range for XLEN
//   OUT_VALID    head entry valid
//   OUT_READY    consumer accepts the head entry
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             FLUSH,
    input  logic [24:0]      IN,
    input  logic [2:0]       IMM_SEL,
    input  logic [TAG_W-1:0] IN_TAG,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [XLEN-1:0]  OUT,
    output logic [TAG_W-1:0] OUT_TAG,
    output logic             OUT_ILLEGAL,
    output logic             OUT_VALID,
    input  logic             OUT_READY
);

    // Only RV32 and RV64 widths are meaningful for this generator.
    if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    localparam logic [2:0] SEL_U     = 3'b000;
    localparam logic [2:0] SEL_J     = 3'b001;
    localparam logic [2:0] SEL_S     = 3'b010;
    localparam logic [2:0] SEL_B     = 3'b011;
    localparam logic [2:0] SEL_I     = 3'b100;
    localparam logic [2:0] SEL_SHAMT = 3'b101;
    localparam logic [2:0] SEL_Z     = 3'b110;
    localparam logic [2:0] SEL_IU    = 3'b111;

    // Builds the immediate as a 32-bit value whose bit 31 already holds the
    // correct extension bit: signed formats replicate the instruction sign,
    // zero-extended formats leave the upper bits clear. Widening to XLEN is
    // then a plain sign extension of this value for every format.
    function automatic logic [31:0] imm32_f(input logic [24:0] ins, input logic [2:0] sel);
        logic [31:0] r;
        case (sel)
            SEL_U:     r = {ins[24:5], 12'd0};
            SEL_J:     r = {{11{ins[24]}}, ins[24], ins[12:5], ins[13], ins[23:14], 1'b0};
            SEL_S:     r = {{20{ins[24]}}, ins[24:18], ins[4:0]};
            SEL_B:     r = {{19{ins[24]}}, ins[24], ins[0], ins[23:18], ins[4:1], 1'b0};
            SEL_I:     r = {{20{ins[24]}}, ins[24:13]};
            SEL_SHAMT: begin
                if (XLEN == 64) begin
                    r = {26'd0, ins[18:13]};
                end else begin
                    r = {27'd0, ins[17:13]};
                end
            end
            SEL_Z:     r = {27'd0, ins[12:8]};
            SEL_IU:    r = {20'd0, ins[24:13]};
            default:   r = 32'd0;
        endcase
        return r;
    endfunction

    // The top shamt bit only exists on RV64; on RV32 it marks an illegal shift.
    function automatic logic illegal_f(input logic [24:0] ins, input logic [2:0] sel);
        logic r;
        if ((sel == SEL_SHAMT) && (XLEN == 32)) begin
            r = ins[18];
        end else begin
            r = 1'b0;
        end
        return r;
    endfunction

    logic [31:0]      imm32_s;
    logic [XLEN-1:0]  imm_s;
    logic             ill_s;
    logic             push_s;
    logic             pop_s;

    logic [XLEN-1:0]  imm_r [2];
    logic [TAG_W-1:0] tag_r [2];
    logic             ill_r [2];
    logic             wr_ptr_r;
    logic             rd_ptr_r;
    logic [1:0]       count_r;

    // Input-side immediate formation and extension to XLEN.
    always_comb begin
        imm32_s = imm32_f(IN, IMM_SEL);
        imm_s   = XLEN'($signed(imm32_s));
        ill_s   = illegal_f(IN, IMM_SEL);
    end

    // Readiness depends only on occupancy and reset, never on OUT_READY, so a
    // full buffer refuses a beat even when its head is popped the same cycle.
    assign IN_READY = (count_r != 2'd2) & ~RESET;
    assign push_s   = IN_VALID & IN_READY;
    assign pop_s    = OUT_VALID & OUT_READY;

    // Head of the buffer: registered entries selected by a registered pointer.
    assign OUT_VALID   = (count_r != 2'd0);
    assign OUT         = imm_r[rd_ptr_r];
    assign OUT_TAG     = tag_r[rd_ptr_r];
    assign OUT_ILLEGAL = ill_r[rd_ptr_r];

    // Buffer storage, pointers and occupancy; reset clears the entry contents
    // too so the head reads as zero, flush only empties the buffer.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            imm_r[0] <= '0;
            imm_r[1] <= '0;
            tag_r[0] <= '0;
            tag_r[1] <= '0;
            ill_r[0] <= 1'b0;
            ill_r[1] <= 1'b0;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else if (FLUSH) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_s) begin
                imm_r[wr_ptr_r] <= imm_s;
                tag_r[wr_ptr_r] <= IN_TAG;
                ill_r[wr_ptr_r] <= ill_s;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_pipe
//
// Drives an XLEN=32 and an XLEN=64 instance from the same stimulus and checks
// both against a reference model that extracts immediates from the full
// 32-bit instruction with shifts and masks, and tracks buffer contents as a
// queue of expected entries.
// -----------------------------------------------------------------------------
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [24:0] in_bits;
    logic [2:0]  sel;
    logic [3:0]  in_tag;
    logic        in_valid;
    logic        out_ready;

    logic        rdy32, rdy64;
    logic [31:0] out32;
    logic [63:0] out64;
    logic [3:0]  tag32, tag64;
    logic        ill32, ill64;
    logic        v32, v64;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(4)) dut32 (
        .CLK(clk), .RESET(rst), .FLUSH(flush), .IN(in_bits), .IMM_SEL(sel),
        .IN_TAG(in_tag), .IN_VALID(in_valid), .IN_READY(rdy32), .OUT(out32),
        .OUT_TAG(tag32), .OUT_ILLEGAL(ill32), .OUT_VALID(v32), .OUT_READY(out_ready)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(4)) dut64 (
        .CLK(clk), .RESET(rst), .FLUSH(flush), .IN(in_bits), .IMM_SEL(sel),
        .IN_TAG(in_tag), .IN_VALID(in_valid), .IN_READY(rdy64), .OUT(out64),
        .OUT_TAG(tag64), .OUT_ILLEGAL(ill64), .OUT_VALID(v64), .OUT_READY(out_ready)
    );

    typedef struct {
        logic [31:0] i32;
        logic [63:0] i64;
        logic        ill;
        logic [3:0]  tag;
    } ent_t;

    ent_t       q[$];
    logic [3:0] popped[$];
    bit         clean;
    int         total = 0;
    int         bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Immediate from the whole instruction word, using the ISA bit positions.
    function automatic logic [63:0] ref_imm(input logic [31:0] instr, input logic [2:0] s, input bit is64);
        logic [63:0]        u;
        logic signed [63:0] sx;
        logic signed [63:0] sh11, sh19, sh20;
        logic [63:0]        r;
        u    = {32'd0, instr};
        sx   = {{32{instr[31]}}, instr};
        sh11 = sx >>> 11;
        sh19 = sx >>> 19;
        sh20 = sx >>> 20;
        case (s)
            3'd0: r = sx & ~64'hFFF;
            3'd1: r = (sh11 & ~64'hFFFFF) | (u & 64'hFF000) | (((u >> 20) & 64'h1) << 11) | ((u >> 20) & 64'h7FE);
            3'd2: r = (sh20 & ~64'h1F) | ((u >> 7) & 64'h1F);
            3'd3: r = (sh19 & ~64'hFFF) | ((u >> 20) & 64'h7E0) | (((u >> 7) & 64'h1) << 11) | (((u >> 8) & 64'hF) << 1);
            3'd4: r = sh20;
            3'd5: r = is64 ? ((u >> 20) & 64'h3F) : ((u >> 20) & 64'h1F);
            3'd6: r = (u >> 15) & 64'h1F;
            default: r = (u >> 20) & 64'hFFF;
        endcase
        return r;
    endfunction

    // Called at posedge+1 with inputs already applied; checks at the falling
    // edge, then advances the model across the next rising edge.
    task automatic cycle();
        bit          rexp, push, pop;
        ent_t        ne;
        logic [31:0] instr;
        logic [63:0] r32;
        #4;
        rexp = (q.size() != 2) && !rst;
        check_val("rdy32", 64'(rdy32), 64'(rexp));
        check_val("rdy64", 64'(rdy64), 64'(rexp));
        check_val("v32", 64'(v32), 64'(q.size() != 0));
        check_val("v64", 64'(v64), 64'(q.size() != 0));
        if (q.size() != 0) begin
            check_val("out32", 64'(out32), 64'(q[0].i32));
            check_val("out64", out64, q[0].i64);
            check_val("tag32", 64'(tag32), 64'(q[0].tag));
            check_val("tag64", 64'(tag64), 64'(q[0].tag));
            check_val("ill32", 64'(ill32), 64'(q[0].ill));
            check_val("ill64", 64'(ill64), 64'd0);
        end else if (clean) begin
            check_val("rst_out32", 64'(out32), 64'd0);
            check_val("rst_out64", out64, 64'd0);
            check_val("rst_tag", 64'(tag32), 64'd0);
            check_val("rst_ill", 64'(ill32), 64'd0);
        end
        if (v32 && out_ready) popped.push_back(tag32);
        push   = in_valid && rexp;
        pop    = (q.size() != 0) && out_ready;
        instr  = {in_bits, 7'h13};
        r32    = ref_imm(instr, sel, 1'b0);
        ne.i32 = r32[31:0];
        ne.i64 = ref_imm(instr, sel, 1'b1);
        ne.ill = (sel == 3'd5) && instr[25];
        ne.tag = in_tag;
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            clean = 1'b1;
        end else if (flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back(ne);
                clean = 1'b0;
            end
        end
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) cycle();
    endtask

    // Single beat into an empty buffer, checked one edge later against constants.
    task automatic direct(input logic [31:0] instr, input logic [2:0] s, input logic [63:0] e32,
                          input logic [63:0] e64, input logic eill, input string nm);
        in_bits   = instr[31:7];
        sel       = s;
        in_tag    = 4'h5;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        check_val({nm, "_v"}, 64'(v32), 64'd1);
        check_val({nm, "_o32"}, 64'(out32), e32);
        check_val({nm, "_o64"}, out64, e64);
        check_val({nm, "_ill32"}, 64'(ill32), 64'(eill));
        check_val({nm, "_ill64"}, 64'(ill64), 64'd0);
        drain();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_bits = 25'd0; sel = 3'd0; in_tag = 4'd0;
        in_valid = 1'b0; out_ready = 1'b1; clean = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cycle();
        rst = 1'b0;
        cycle();

        // Directed immediates
        direct(32'hFFF00093, 3'b100, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, "addi_i");
        direct(32'hFFF00093, 3'b111, 64'h00000FFF, 64'h0000000000000FFF, 1'b0, "addi_iu");
        direct(32'hFFDFF06F, 3'b001, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0, "jal");
        direct(32'h123450B7, 3'b000, 64'h12345000, 64'h0000000012345000, 1'b0, "lui");
        direct(32'h02109093, 3'b101, 64'h00000001, 64'h0000000000000021, 1'b1, "slli33");
        direct(32'h340FD0F3, 3'b110, 64'h0000001F, 64'h000000000000001F, 1'b0, "csrrwi");

        // Backpressure: two beats fill the buffer, the third is held off
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_bits   = 25'h0ABCDE;
        sel       = 3'b010;
        in_tag    = 4'd1; cycle();
        in_tag    = 4'd2; cycle();
        check_val("bp_full_rdy", 64'(rdy32), 64'd0);
        in_tag    = 4'd3; cycle(); cycle();
        check_val("bp_held_head", 64'(tag32), 64'd1);
        popped.delete();
        out_ready = 1'b1;
        cycle();
        cycle();
        in_valid = 1'b0;
        cycle(); cycle();
        check_val("bp_npop", 64'(popped.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < popped.size()) check_val("bp_order", 64'(popped[i]), 64'(i + 1));
        end

        // Flush with a full buffer and a same-cycle beat offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_tag = 4'd4; cycle();
        in_tag = 4'd5; cycle();
        flush = 1'b1; in_tag = 4'd6; cycle();
        flush = 1'b0; in_valid = 1'b0;
        check_val("flush_full_v", 64'(v32), 64'd0);
        check_val("flush_full_v64", 64'(v64), 64'd0);
        check_val("flush_rdy", 64'(rdy32), 64'd1);
        // Flush with one entry and a push that must be discarded
        in_valid = 1'b1; in_tag = 4'd7; cycle();
        flush = 1'b1; in_tag = 4'd8; cycle();
        flush = 1'b0; in_valid = 1'b0;
        check_val("flush_push_v", 64'(v32), 64'd0);
        cycle();
        check_val("flush_push_v2", 64'(v32), 64'd0);

        // Reset mid-stream
        in_valid = 1'b1; in_bits = 25'h1FFFFFF; sel = 3'b100; in_tag = 4'hF;
        cycle(); cycle();
        rst = 1'b1;
        cycle();
        check_val("mrst_rdy", 64'(rdy32), 64'd0);
        check_val("mrst_v", 64'(v32), 64'd0);
        check_val("mrst_out32", 64'(out32), 64'd0);
        check_val("mrst_out64", out64, 64'd0);
        check_val("mrst_tag", 64'(tag64), 64'd0);
        check_val("mrst_ill", 64'(ill32), 64'd0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check_val("mrst_rel_rdy", 64'(rdy32), 64'd1);
        check_val("mrst_rel_rdy64", 64'(rdy64), 64'd1);
        #0;
        @(posedge clk);
        #1;

        // Randomized traffic with phases of steady, random and sparse draining
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 199) == 0);
            flush    = ($urandom_range(0, 39) == 0);
            in_valid = ($urandom_range(0, 9) < 7);
            case ((i / 200) % 3)
                0:       out_ready = 1'b1;
                1:       out_ready = $urandom_range(0, 1) == 1;
                default: out_ready = ($urandom_range(0, 4) == 0);
            endcase
            in_bits = 25'($urandom);
            sel     = 3'($urandom_range(0, 7));
            in_tag  = 4'($urandom);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
